// File: rtl/power_stress_array.sv
// power_stress_array: ramp-controlled LFSR-driven multiplier lane array.
// Define POWER_STRESS_SIGNATURE_EN to build the product MISR on SIGNATURE.
module power_stress_array #(
  parameter int          LANES       = 32,
  parameter int          WIDTH       = 32,
  parameter int          RAMP_CYCLES = 256,
  parameter logic [31:0] LFSR_SEED   = 32'hACE12468,
  localparam int         CW          = $clog2(LANES + 1)
) (
  input  logic             ICE_CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [CW-1:0]    TARGET,
  output logic [CW-1:0]    ACTIVE,
  output logic [1:0]       STATE,
  output logic             RAMPING,
  output logic             ACTIVITY,
  output logic [2*WIDTH-1:0] SIGNATURE
);

  localparam int PW  = 2 * WIDTH;
  localparam int RCW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [RCW-1:0] LAST = RCW'(RAMP_CYCLES - 1);
  localparam logic [CW-1:0]  MAXL = CW'(LANES);
  localparam logic [31:0]    TAPS = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } state_t;

  state_t         state;
  state_t         nxt;
  logic [RCW-1:0] ramp_cnt;
  logic [CW-1:0]  tgt;
  logic           same;
  logic           ramp_step;

  logic [31:0]       lfsr;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic [WIDTH-1:0]  a [LANES];
  logic [WIDTH-1:0]  b [LANES];
  logic [PW-1:0]     p [LANES];
  logic [PW-1:0]     por;

  assign STATE = state;

  always_comb begin
    tgt = '0;
    if (EN) tgt = (TARGET > MAXL) ? MAXL : TARGET;
    priority case (1'b1)
      (ACTIVE < tgt):  nxt = UP;
      (ACTIVE > tgt):  nxt = DOWN;
      (ACTIVE != '0):  nxt = HOLD;
      default:         nxt = IDLE;
    endcase
    // a step only completes while the direction is unchanged
    same = (nxt == state) && (state == UP || state == DOWN);
    ramp_step = same && (ramp_cnt == LAST);
  end

  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      state    <= IDLE;
      ACTIVE   <= '0;
      ramp_cnt <= '0;
      RAMPING  <= 1'b0;
    end else begin
      state   <= nxt;
      RAMPING <= (nxt == UP) || (nxt == DOWN);
      if (!same || ramp_step) ramp_cnt <= '0;
      else ramp_cnt <= ramp_cnt + RCW'(1);
      if (ramp_step)
        ACTIVE <= (state == UP) ? ACTIVE + CW'(1)
                                : ACTIVE - CW'(1);
    end
  end

  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      lfsr <= LFSR_SEED;
      opa  <= '0;
      opb  <= '0;
      for (int i = 0; i < LANES; i++) begin
        a[i] <= '0;
        b[i] <= '0;
        p[i] <= '0;
      end
    end else begin
      if (ACTIVE != '0)
        lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
      opa <= lfsr[WIDTH-1:0];
      opb <= WIDTH'({lfsr[15:0], lfsr[31:16]});
      for (int i = 0; i < LANES; i++) begin
        if (ACTIVE > CW'(i)) begin
          a[i] <= opa;
          b[i] <= opb ^ WIDTH'(i);
          p[i] <= {{WIDTH{1'b0}}, a[i]} * {{WIDTH{1'b0}}, b[i]};
        end else begin
          a[i] <= '0;
          b[i] <= '0;
          p[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    por = '0;
    for (int i = 0; i < LANES; i++) por = por | p[i];
  end

  always_ff @(posedge ICE_CLK) begin
    if (RST) ACTIVITY <= 1'b0;
    else ACTIVITY <= |por;
  end

`ifdef POWER_STRESS_SIGNATURE_EN
  logic [PW-1:0] pxor;

  always_comb begin
    pxor = '0;
    for (int i = 0; i < LANES; i++) pxor = pxor ^ p[i];
  end

  always_ff @(posedge ICE_CLK) begin
    if (RST) SIGNATURE <= '0;
    else SIGNATURE <= {SIGNATURE[PW-2:0], SIGNATURE[PW-1]} ^ pxor;
  end
`else
  assign SIGNATURE = '0;
`endif

endmodule
